// File: rtl/line_packer_pkg.sv
// Shared definitions for the line packer and the bit-plane memory it feeds.
// Default geometry, FSM encoding and the bit-to-line index mapping.
package line_packer_pkg;

    localparam int unsigned SIZE_DEF    = 5;
    localparam int unsigned MEMSIZE_DEF = 25;

    typedef enum logic {
        StFill  = 1'b0,
        StStall = 1'b1
    } state_e;

    // Serial bit k of a line lands at line[memsize-1-k]; the memory reads with the same map.
    function automatic int unsigned map_idx(input int unsigned k,
                                            input int unsigned memsize = MEMSIZE_DEF);
        return memsize - 1 - k;
    endfunction

endpackage

// File: rtl/line_packer_if.sv
// Serial-bit input and packed-line output of the line packer, bundled as one interface.
// Optional line_par member exists only when LINE_PARITY_EN is defined.
interface line_packer_if
    import line_packer_pkg::*;
#(
    parameter int unsigned SIZE    = SIZE_DEF,
    parameter int unsigned MEMSIZE = MEMSIZE_DEF
);

    logic               in_bit;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [MEMSIZE-1:0] line_out;
    logic               line_valid;
    logic               line_ready;
    logic [SIZE-1:0]    count;
`ifdef LINE_PARITY_EN
    logic               line_par;
`endif

    // Source/sink side: drives the serial bits and consumes lines.
    modport master (
`ifdef LINE_PARITY_EN
        input  line_par,
`endif
        output in_bit,
        output in_valid,
        output flush,
        output line_ready,
        input  in_ready,
        input  line_out,
        input  line_valid,
        input  count
    );

    // Packer side.
    modport slave (
`ifdef LINE_PARITY_EN
        output line_par,
`endif
        input  in_bit,
        input  in_valid,
        input  flush,
        input  line_ready,
        output in_ready,
        output line_out,
        output line_valid,
        output count
    );

endinterface

// File: rtl/line_packer_line_out_reg.sv
// Output holding register for packed lines: valid/ready handshake, load while consumed.
// Adds a registered even-parity bit when LINE_PARITY_EN is defined.
module line_packer_line_out_reg
    import line_packer_pkg::*;
#(
    parameter int unsigned MEMSIZE = MEMSIZE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MEMSIZE-1:0] load_data,
    input  logic               line_ready,
    output logic [MEMSIZE-1:0] line_out,
`ifdef LINE_PARITY_EN
    output logic               line_par,
`endif
    output logic               line_valid
);

    logic [MEMSIZE-1:0] data_q;
    logic               valid_q;
`ifdef LINE_PARITY_EN
    logic               par_q;
`endif

    // The caller only loads when the register is empty or being consumed this cycle,
    // so a load always wins over the consume and keeps valid high with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
        end else if (line_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef LINE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^load_data;
        end
    end

    assign line_par = par_q;
`endif

    assign line_out   = data_q;
    assign line_valid = valid_q;

endmodule

// File: rtl/line_packer.sv
// Serial-to-line assembler: packs MEMSIZE bits into one line for a 5x5 bit-plane memory load.
// LINE_PARITY_EN adds a registered even-parity output alongside the line.
module line_packer
    import line_packer_pkg::*;
#(
    parameter int unsigned SIZE    = SIZE_DEF,
    parameter int unsigned MEMSIZE = MEMSIZE_DEF
) (
    input logic           clk,
    input logic           rst,
    line_packer_if.slave  lp
);

    localparam logic [SIZE-1:0] CountMax = SIZE'(MEMSIZE - 1);

    state_e             state_q, state_d;
    logic [MEMSIZE-1:0] asm_q, asm_d, asm_fill;
    logic [SIZE-1:0]    count_q, count_d;
    logic [SIZE-1:0]    wr_idx;
    logic               accept;
    logic               last_bit;
    logic               close;
    logic               out_free;
    logic               load;
    logic [MEMSIZE-1:0] load_data;

    assign lp.in_ready = (state_q == StFill);
    assign accept      = lp.in_valid && lp.in_ready;
    assign out_free    = !lp.line_valid || lp.line_ready;
    assign wr_idx      = SIZE'(map_idx(32'(count_q), MEMSIZE));
    assign last_bit    = accept && (count_q == CountMax);
    // A same-cycle accepted bit joins the line before a flush closes it.
    assign close       = last_bit || (lp.flush && (accept || (count_q != '0)));

    always_comb begin
        asm_fill = asm_q;
        if (accept) begin
            asm_fill[wr_idx] = lp.in_bit;
        end
    end

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        count_d   = count_q;
        load      = 1'b0;
        load_data = asm_q;
        unique case (state_q)
            StFill: begin
                if (close) begin
                    if (out_free) begin
                        load      = 1'b1;
                        load_data = asm_fill;
                        asm_d     = '0;
                        count_d   = '0;
                    end else begin
                        // Output still occupied: park the finished line in asm_q.
                        state_d = StStall;
                        asm_d   = asm_fill;
                        count_d = last_bit ? CountMax : count_q + SIZE'(accept);
                    end
                end else if (accept) begin
                    asm_d   = asm_fill;
                    count_d = count_q + SIZE'(1);
                end
            end
            StStall: begin
                if (lp.line_ready) begin
                    load      = 1'b1;
                    load_data = asm_q;
                    asm_d     = '0;
                    count_d   = '0;
                    state_d   = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            asm_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            count_q <= count_d;
        end
    end

    assign lp.count = count_q;

    line_packer_line_out_reg #(
        .MEMSIZE (MEMSIZE)
    ) u_line_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .line_ready (lp.line_ready),
        .line_out   (lp.line_out),
`ifdef LINE_PARITY_EN
        .line_par   (lp.line_par),
`endif
        .line_valid (lp.line_valid)
    );

endmodule

// File: tb/tb_line_packer.sv
// Self-checking bench for line_packer: scenario tasks plus a scoreboard of expected lines.
// Parity scenario runs only when LINE_PARITY_EN is defined.
module tb_line_packer;
    import line_packer_pkg::*;

    localparam int unsigned MS = MEMSIZE_DEF;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [MS-1:0] exp_q[$];
    logic [MS-1:0] mon_exp;

    always #5 clk = ~clk;

    line_packer_if lp_if ();

    line_packer u_dut (
        .clk (clk),
        .rst (rst),
        .lp  (lp_if)
    );

    // Scoreboard: every consumed line must match the oldest expected line.
    always @(negedge clk) begin
        if (rst === 1'b0 && lp_if.line_valid === 1'b1 && lp_if.line_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got line %h, none expected", lp_if.line_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (lp_if.line_out !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_line: got %h expected %h", lp_if.line_out, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        lp_if.in_valid = 1'b1;
        lp_if.in_bit   = b;
        step();
        lp_if.in_valid = 1'b0;
        lp_if.in_bit   = 1'b0;
    endtask

    // Send bits so that the finished line equals 'line' (first bit is the MSB).
    task automatic drive_line(input logic [MS-1:0] line);
        for (int k = 0; k < MS; k++) drive_bit(line[MS-1-k]);
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        lp_if.in_bit     = 1'b0;
        lp_if.in_valid   = 1'b0;
        lp_if.flush      = 1'b0;
        lp_if.line_ready = 1'b0;
        step();
        step();
        checks++;
        if (lp_if.line_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b expected 0", lp_if.line_valid);
        end
        checks++;
        if (lp_if.count !== 5'd0) begin
            errors++; $display("FAIL rst_count: got %0d expected 0", lp_if.count);
        end
        checks++;
        if (lp_if.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready: got %b expected 1", lp_if.in_ready);
        end
        checks++;
        if (lp_if.line_out !== 25'h0) begin
            errors++; $display("FAIL rst_line_out: got %h expected 0", lp_if.line_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_alternating();
        lp_if.line_ready = 1'b1;
        exp_q.push_back(25'h1555555);
        for (int k = 0; k < MS - 1; k++) drive_bit(k % 2 == 0);
        checks++;
        if (lp_if.count !== 5'd24 || lp_if.line_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_pre_last: got count=%0d valid=%b expected count=24 valid=0",
                     lp_if.count, lp_if.line_valid);
        end
        drive_bit(1'b1);
        checks++;
        if (lp_if.line_valid !== 1'b1 || lp_if.line_out !== 25'h1555555) begin
            errors++;
            $display("FAIL alt_line: got valid=%b line=%h expected valid=1 line=1555555",
                     lp_if.line_valid, lp_if.line_out);
        end
        checks++;
        if (lp_if.count !== 5'd0) begin
            errors++; $display("FAIL alt_count: got %0d expected 0", lp_if.count);
        end
        step();
        checks++;
        if (lp_if.line_valid !== 1'b0) begin
            errors++; $display("FAIL alt_valid_drop: got %b expected 0", lp_if.line_valid);
        end
    endtask

    task automatic test_stall();
        lp_if.line_ready = 1'b0;
        exp_q.push_back(25'h1FFFFFF);
        drive_line(25'h1FFFFFF);
        checks++;
        if (lp_if.line_valid !== 1'b1 || lp_if.line_out !== 25'h1FFFFFF) begin
            errors++;
            $display("FAIL stall_a: got valid=%b line=%h expected valid=1 line=1ffffff",
                     lp_if.line_valid, lp_if.line_out);
        end
        exp_q.push_back(25'h0);
        drive_line(25'h0);
        checks++;
        if (lp_if.in_ready !== 1'b0 || lp_if.count !== 5'd24) begin
            errors++;
            $display("FAIL stall_enter: got in_ready=%b count=%0d expected in_ready=0 count=24",
                     lp_if.in_ready, lp_if.count);
        end
        // Flush while stalled must be ignored.
        lp_if.flush = 1'b1;
        step();
        lp_if.flush = 1'b0;
        step();
        checks++;
        if (lp_if.line_out !== 25'h1FFFFFF || lp_if.line_valid !== 1'b1
            || lp_if.in_ready !== 1'b0 || lp_if.count !== 5'd24) begin
            errors++;
            $display("FAIL stall_flush: got line=%h valid=%b in_ready=%b count=%0d expected 1ffffff 1 0 24",
                     lp_if.line_out, lp_if.line_valid, lp_if.in_ready, lp_if.count);
        end
        lp_if.line_ready = 1'b1;
        step();
        checks++;
        if (lp_if.line_out !== 25'h0 || lp_if.line_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got line=%h valid=%b expected line=0 valid=1",
                     lp_if.line_out, lp_if.line_valid);
        end
        checks++;
        if (lp_if.in_ready !== 1'b1 || lp_if.count !== 5'd0) begin
            errors++;
            $display("FAIL stall_resume: got in_ready=%b count=%0d expected 1 0",
                     lp_if.in_ready, lp_if.count);
        end
        step();
        checks++;
        if (lp_if.line_valid !== 1'b0) begin
            errors++; $display("FAIL stall_drain: got valid=%b expected 0", lp_if.line_valid);
        end
    endtask

    task automatic test_flush();
        lp_if.line_ready = 1'b1;
        exp_q.push_back(25'h1C00000);
        for (int k = 0; k < 3; k++) drive_bit(1'b1);
        checks++;
        if (lp_if.count !== 5'd3) begin
            errors++; $display("FAIL flush_pre_count: got %0d expected 3", lp_if.count);
        end
        lp_if.flush = 1'b1;
        step();
        lp_if.flush = 1'b0;
        checks++;
        if (lp_if.line_valid !== 1'b1 || lp_if.line_out !== 25'h1C00000
            || lp_if.count !== 5'd0) begin
            errors++;
            $display("FAIL flush_partial: got valid=%b line=%h count=%0d expected 1 1c00000 0",
                     lp_if.line_valid, lp_if.line_out, lp_if.count);
        end
        step();
        // Bit accepted on the flush cycle goes in before the line closes.
        exp_q.push_back(25'h1800000);
        drive_bit(1'b1);
        lp_if.flush = 1'b1;
        drive_bit(1'b1);
        lp_if.flush = 1'b0;
        checks++;
        if (lp_if.line_valid !== 1'b1 || lp_if.line_out !== 25'h1800000) begin
            errors++;
            $display("FAIL flush_with_bit: got valid=%b line=%h expected 1 1800000",
                     lp_if.line_valid, lp_if.line_out);
        end
        step();
        lp_if.flush = 1'b1;
        step();
        lp_if.flush = 1'b0;
        checks++;
        if (lp_if.line_valid !== 1'b0 || lp_if.count !== 5'd0) begin
            errors++;
            $display("FAIL flush_empty: got valid=%b count=%0d expected 0 0",
                     lp_if.line_valid, lp_if.count);
        end
    endtask

    task automatic test_back_to_back();
        logic [MS-1:0] l1;
        logic [MS-1:0] l2;
        l1 = 25'($urandom);
        l2 = 25'($urandom);
        lp_if.line_ready = 1'b1;
        exp_q.push_back(l1);
        exp_q.push_back(l2);
        drive_line(l1);
        drive_line(l2);
        checks++;
        if (lp_if.line_valid !== 1'b1 || lp_if.line_out !== l2) begin
            errors++;
            $display("FAIL b2b_second: got valid=%b line=%h expected 1 %h",
                     lp_if.line_valid, lp_if.line_out, l2);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [MS-1:0] l;
        lp_if.line_ready = 1'b0;
        drive_line(25'($urandom));
        for (int k = 0; k < 10; k++) drive_bit(1'($urandom));
        checks++;
        if (lp_if.count !== 5'd10 || lp_if.line_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre: got count=%0d valid=%b expected 10 1",
                     lp_if.count, lp_if.line_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (lp_if.line_valid !== 1'b0 || lp_if.count !== 5'd0 || lp_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_after: got valid=%b count=%0d in_ready=%b expected 0 0 1",
                     lp_if.line_valid, lp_if.count, lp_if.in_ready);
        end
        lp_if.line_ready = 1'b1;
        l = 25'($urandom);
        exp_q.push_back(l);
        drive_line(l);
        checks++;
        if (lp_if.line_valid !== 1'b1 || lp_if.line_out !== l) begin
            errors++;
            $display("FAIL rmid_clean: got valid=%b line=%h expected 1 %h",
                     lp_if.line_valid, lp_if.line_out, l);
        end
        step();
    endtask

`ifdef LINE_PARITY_EN
    task automatic test_parity();
        lp_if.line_ready = 1'b1;
        exp_q.push_back(25'h0000007);
        drive_line(25'h0000007);
        checks++;
        if (lp_if.line_par !== 1'b1) begin
            errors++; $display("FAIL par_odd: got %b expected 1", lp_if.line_par);
        end
        exp_q.push_back(25'h0000003);
        drive_line(25'h0000003);
        checks++;
        if (lp_if.line_par !== 1'b0) begin
            errors++; $display("FAIL par_even: got %b expected 0", lp_if.line_par);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_alternating();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
`ifdef LINE_PARITY_EN
        test_parity();
`endif
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d lines still expected, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
